// File: rtl/float_to_fixed.sv
// Serial float-to-fixed converter: takes one FPU result (sign/exp6/mant25, bias 31)
// and shifts its significand one bit per clock into a signed Q(INT_W).(FRAC_W) value.
module float_to_fixed #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [3:0]               in_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_W+FRAC_W-1:0]  out_data,
  output logic [3:0]               out_status,
  output logic                     busy
);

  localparam int OUT_W = INT_W + FRAC_W;
  localparam int ACC_W = OUT_W + 1;
  localparam int K_W   = 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PACK  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] ST_EXACT = 4'b0001;
  localparam logic [3:0] ST_OVF   = 4'b0010;
  localparam logic [3:0] ST_UNF   = 4'b0100;
  localparam logic [3:0] ST_INEX  = 4'b1000;

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  zero_q, zero_d;
  logic                  ovf_in_q, ovf_in_d;
  logic                  sticky_q, sticky_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic signed [K_W-1:0] k_q, k_d;
  logic [OUT_W-1:0]      out_data_q, out_data_d;
  logic [3:0]            out_status_q, out_status_d;

  logic signed [K_W-1:0] k_init;
  logic [OUT_W-1:0]      mag;
  logic                  too_big;
  logic                  unused_status;

  // Shift distance that places the 26-bit significand on the output binary point.
  assign k_init = K_W'(in_data[30:25]) + K_W'(FRAC_W) - K_W'(56);
  assign mag    = acc_q[OUT_W-1:0];
  // The negative range reaches exactly 2^(OUT_W-1); the positive range stops one short.
  assign too_big = acc_q[OUT_W] | (mag[OUT_W-1] & (~sign_q | (|mag[OUT_W-2:0])));
  assign unused_status = ^{in_status[3:2], in_status[0]};

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    zero_d       = zero_q;
    ovf_in_d     = ovf_in_q;
    sticky_d     = sticky_q;
    acc_d        = acc_q;
    k_d          = k_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = in_data[31];
          zero_d   = (in_data[30:25] == 6'd0);
          ovf_in_d = in_status[1];
          sticky_d = 1'b0;
          acc_d    = ACC_W'({1'b1, in_data[24:0]});
          k_d      = k_init;
          state_d  = ((in_data[30:25] == 6'd0) || in_status[1]) ? S_PACK : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (k_q == '0) begin
          state_d = S_PACK;
        end else if (!k_q[K_W-1]) begin
          acc_d = acc_q << 1;
          k_d   = k_q - K_W'(1);
          if (acc_d[OUT_W] || (k_d == '0)) state_d = S_PACK;
        end else begin
          sticky_d = sticky_q | acc_q[0];
          acc_d    = acc_q >> 1;
          k_d      = k_q + K_W'(1);
          if ((acc_d == '0) || (k_d == '0)) state_d = S_PACK;
        end
      end
      S_PACK: begin
        state_d = S_DONE;
        if (ovf_in_q || (!zero_q && too_big)) begin
          out_data_d   = sign_q ? MIN_NEG : MAX_POS;
          out_status_d = ST_OVF;
        end else if (zero_q) begin
          out_data_d   = '0;
          out_status_d = ST_EXACT;
        end else if (mag == '0) begin
          out_data_d   = '0;
          out_status_d = ST_UNF;
        end else begin
          out_data_d   = sign_q ? (~mag + 1'b1) : mag;
          out_status_d = sticky_q ? ST_INEX : ST_EXACT;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sign_q       <= 1'b0;
      zero_q       <= 1'b0;
      ovf_in_q     <= 1'b0;
      sticky_q     <= 1'b0;
      acc_q        <= '0;
      k_q          <= '0;
      out_data_q   <= '0;
      out_status_q <= ST_EXACT;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      zero_q       <= zero_d;
      ovf_in_q     <= ovf_in_d;
      sticky_q     <= sticky_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_data   = out_data_q;
  assign out_status = out_status_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Scoreboard bench for float_to_fixed: a behavioural model predicts each result
// when the operand is accepted, and the monitor pops and compares on the output handshake.
module tb_float_to_fixed;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_status = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  float_to_fixed #(.INT_W(16), .FRAC_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_status(in_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_status(out_status),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: direct (non-iterative) scaling of the significand by 2^k in 64-bit math.
  function automatic void model(input logic [31:0] d, input logic [3:0] s,
                                output logic [31:0] od, output logic [3:0] os);
    logic        sign;
    logic [63:0] sig;
    logic [63:0] mag;
    logic        sticky;
    int          k;
    sign = d[31];
    sig  = {38'd0, 1'b1, d[24:0]};
    k    = int'(d[30:25]) - 40;
    sticky = 1'b0;
    if (s[1]) begin
      od = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      os = 4'b0010;
    end else if (d[30:25] == 6'd0) begin
      od = 32'h0;
      os = 4'b0001;
    end else begin
      if (k >= 0) begin
        mag = sig << k;
      end else begin
        mag    = sig >> (-k);
        sticky = ((sig & ((64'd1 << (-k)) - 64'd1)) != 64'd0);
      end
      if ((!sign && mag > 64'h7FFF_FFFF) || (sign && mag > 64'h8000_0000)) begin
        od = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        os = 4'b0010;
      end else if (mag == 64'd0) begin
        od = 32'h0;
        os = 4'b0100;
      end else begin
        od = mag[31:0];
        if (sign) od = -od;
        os = sticky ? 4'b1000 : 4'b0001;
      end
    end
  endfunction

  // lat > 0 requests a check of accept-to-out_valid latency for this operand.
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] s, input int lat);
    exp_t        e;
    logic        ok;
    logic [31:0] od;
    logic [3:0]  os;
    ok = 1'b0;
    in_data   = d;
    in_status = s;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      model(d, s, od, os);
      e.data    = od;
      e.status  = os;
      e.lat     = lat;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      if (out_valid && !prev_valid && sb.size() > 0 && sb[0].lat > 0)
        checkOutput("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("data", out_data, e.data);
          checkOutput("status", {28'd0, out_status}, {28'd0, e.status});
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] vec_data [13] = '{
    32'h3E00_0000, 32'hBE00_0000, 32'h3F00_0000, 32'h5C00_0000, 32'hDC00_0000,
    32'h0200_0000, 32'h0000_0000, 32'h3E00_0000, 32'hBE00_0000, 32'h3E00_0001,
    32'h5000_0000, 32'h8000_0000, 32'h5BFF_FFFF
  };
  logic [3:0] vec_status [13] = '{
    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
    4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001,
    4'b1001, 4'b0001, 4'b0101
  };
  int vec_lat [13] = '{11, 11, 11, 0, 0, 0, 2, 2, 2, 11, 0, 2, 0};

  initial begin
    logic [31:0] held;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] od;
    logic [3:0]  os;
    exp_t        e;

    #2 reset = 1'b0;
    #3;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_status", {28'd0, out_status}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Directed operands, including the zero/overflow fast paths.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vec_data[i], vec_status[i], vec_lat[i]);
      if (i == 0) checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
      waitDrain();
    end

    // Backpressure: result must hold and a waiting operand must not be taken early.
    out_ready = 1'b0;
    applyStimulus(32'h3F00_0000, 4'b0001, 0);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clock);
    checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held = out_data;
    in_data   = 32'h3E00_0000;
    in_status = 4'b0001;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("bp_stable", out_data, held);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp_no_reaccept", {31'd0, busy}, 32'd0);
    checkOutput("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_second_taken", {31'd0, busy}, 32'd1);
    model(32'h3E00_0000, 4'b0001, od, os);
    e.data = od; e.status = os; e.lat = 11; e.acc_cyc = cyc;
    sb.push_back(e);
    waitDrain();

    // Reset pulse in the middle of a long right-shift.
    applyStimulus(32'h0A00_0000, 4'b0001, 0);
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_data", out_data, 32'd0);
    checkOutput("midrst_out_status", {28'd0, out_status}, 32'd1);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    applyStimulus(32'h3E00_0000, 4'b0001, 11);
    waitDrain();

    // Random operands across the interesting exponent range.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      d[30:25] = 6'($urandom_range(20, 58));
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) != 0) s[1] = 1'b0;
      applyStimulus(d, s, 0);
      waitDrain();
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
